// File: rtl/seg_display_driver_pkg.sv
// Shared definitions for the 8-digit seven-segment display driver: modes, char codes, glyphs,
// display register layout and the decode helpers used by the engine and the top level.
package seg_display_driver_pkg;

  localparam int unsigned DIGITS = 8;

  localparam logic [1:0] SEG_MODE_NUM  = 2'd0;
  localparam logic [1:0] SEG_MODE_CHAR = 2'd1;

  // Character codes, matching what the upstream display-data mux emits.
  localparam logic [31:0] CHAR_T = 32'd1;
  localparam logic [31:0] CHAR_A = 32'd2;
  localparam logic [31:0] CHAR_B = 32'd3;
  localparam logic [31:0] CHAR_C = 32'd4;
  localparam logic [31:0] CHAR_J = 32'd5;

  localparam logic [7:0] GLYPH_T     = 8'h78;
  localparam logic [7:0] GLYPH_A     = 8'h77;
  localparam logic [7:0] GLYPH_B     = 8'h7C;
  localparam logic [7:0] GLYPH_C     = 8'h39;
  localparam logic [7:0] GLYPH_J     = 8'h1E;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  // Committed display content; for char modes 'digits' carries the raw char code.
  typedef struct packed {
    logic [1:0]  mode;
    logic        ovf;
    logic [31:0] digits;
  } disp_t;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = 8'h3F;
      4'd1:    g = 8'h06;
      4'd2:    g = 8'h5B;
      4'd3:    g = 8'h4F;
      4'd4:    g = 8'h66;
      4'd5:    g = 8'h6D;
      4'd6:    g = 8'h7D;
      4'd7:    g = 8'h07;
      4'd8:    g = 8'h7F;
      4'd9:    g = 8'h6F;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Double-dabble adjust step: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [39:0] bcd_add3(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    for (int i = 0; i < 10; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // All eight glyphs of a display register, digit 0 in the low byte.
  function automatic logic [63:0] disp_glyphs(input disp_t d);
    logic [63:0] g;
    logic        lead;
    logic [3:0]  nib;
    g    = '0;
    lead = 1'b1;
    if (d.mode == SEG_MODE_NUM) begin
      if (d.ovf) begin
        g = {DIGITS{GLYPH_DASH}};
      end else begin
        // Walk from the most significant digit so leading zeros stay blank.
        for (int i = DIGITS - 1; i >= 0; i--) begin
          nib = d.digits[i*4 +: 4];
          if (nib != 4'd0 || i == 0) lead = 1'b0;
          g[i*8 +: 8] = lead ? GLYPH_BLANK : digit_glyph(nib);
        end
      end
    end else if (d.mode == SEG_MODE_CHAR) begin
      case (d.digits)
        CHAR_T:  g[7:0] = GLYPH_T;
        CHAR_A:  g[7:0] = GLYPH_A;
        CHAR_B:  g[7:0] = GLYPH_B;
        CHAR_C:  g[7:0] = GLYPH_C;
        CHAR_J:  g[7:0] = GLYPH_J;
        default: g = '0;
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: 32-bit binary to 10 BCD digits in LOAD + 32 SHIFT + DONE.
module seg_display_driver_bin2bcd_seq
  import seg_display_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] data,
  output logic        done,
  output logic        busy,
  output logic [39:0] bcd
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [39:0] bcd_q, bcd_d, adj;
  logic [31:0] bin_q, bin_d;
  logic [4:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    adj     = '0;
    case (state_q)
      StIdle: ;
      StLoad: begin
        bcd_d   = '0;
        bin_d   = data;
        cnt_d   = 5'd0;
        state_d = StShift;
      end
      StShift: begin
        adj            = bcd_add3(bcd_q);
        {bcd_d, bin_d} = {adj[38:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A new start discards whatever is in flight and reloads.
    if (start)      state_d = StLoad;
    else if (abort) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done = (state_q == StDone);
  assign busy = (state_q != StIdle);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_driver.sv
// 8-digit multiplexed seven-segment driver: change detect, BCD conversion, display register,
// glyph decode and digit scan.
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seg_data,
  input  logic [1:0]  seg_mode,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        busy
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [33:0]     snap_q;
  logic            change;
  logic            char_pend_q;
  logic            conv_start, conv_abort, conv_done, conv_busy;
  logic [39:0]     conv_bcd;
  disp_t           disp_q, disp_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      idx_q, idx_d;
  logic [63:0]     glyphs;
  logic [7:0]      an_q, an_d, seg_q, seg_d;

  assign change     = ({seg_mode, seg_data} != snap_q);
  assign conv_start = change && (seg_mode == SEG_MODE_NUM);
  assign conv_abort = change && (seg_mode != SEG_MODE_NUM);

  seg_display_driver_bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .abort (conv_abort),
    .data  (snap_q[31:0]),
    .done  (conv_done),
    .busy  (conv_busy),
    .bcd   (conv_bcd)
  );

  // A pending input change wins over any commit so stale values never reach the display.
  always_comb begin
    disp_d = disp_q;
    if (!change) begin
      if (conv_done) begin
        disp_d = '{mode: SEG_MODE_NUM, ovf: |conv_bcd[39:32], digits: conv_bcd[31:0]};
      end else if (char_pend_q) begin
        disp_d = '{mode: snap_q[33:32], ovf: 1'b0, digits: snap_q[31:0]};
      end
    end
  end

  always_comb begin
    if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      div_d = div_q + DivW'(1);
      idx_d = idx_q;
    end
    // Decode from the next display value so a commit on a scan edge is seen immediately.
    glyphs = disp_glyphs(disp_d);
    an_d   = 8'd1 << idx_d;
    seg_d  = glyphs[idx_d*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q      <= '0;
      char_pend_q <= 1'b0;
      disp_q      <= '0;
      div_q       <= '0;
      idx_q       <= '0;
      an_q        <= '0;
      seg_q       <= '0;
    end else begin
      snap_q      <= {seg_mode, seg_data};
      char_pend_q <= conv_abort;
      disp_q      <= disp_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign busy = conv_busy;

endmodule
